dma_dsc_issuer: RTL
===================

// Module: dma_dsc_issuer
// PURPOSE
// - Initiator side of one XDMA descriptor-bypass channel (c2h or h2c, one instance each).
// - Accepts a user transfer command (host addr, byte length, tag) and splits it into descriptors.
//   Each descriptor is at most MAX_DSC_BYTES and never crosses a MAX_DSC_BYTES-aligned boundary.
// - Drives dsc_byp_addr/len/load into the DMA wrapper, then monitors the paired 512-bit data stream.
//   Emits a done record once cmd_len bytes have moved.
// PARAMETERS
// - MAX_DSC_BYTES  32768  max bytes per descriptor; power of two, <= 2^27
// - TAG_W          8      command tag width
// - KEEP_W         64     byte-enable width of the monitored stream (512-bit data)
// PORTS
// - pcie_clk       in   1       DMA user clock
// - pcie_rst       in   1       async, active-high reset
// - cmd_valid      in   1       command offer
// - cmd_ready      out  1       command accepted when cmd_valid & cmd_ready
// - cmd_addr       in   64      host byte address
// - cmd_len        in   32      byte length; 0 is legal
// - cmd_tag        in   TAG_W   returned on done
// - dsc_byp_ready  in   1       wrapper can take a descriptor
// - dsc_byp_addr   out  64      descriptor host address
// - dsc_byp_len    out  32      descriptor bytes; only [27:0] is consumed downstream
// - dsc_byp_load   out  1       descriptor strobe
// - mon_valid      in   1       paired stream tvalid (observe only)
// - mon_ready      in   1       paired stream tready (observe only)
// - mon_keep       in   KEEP_W  paired stream tkeep
// - done_valid     out  1       one-cycle completion pulse
// - done_tag       out  TAG_W   tag of the completed command
// - done_len       out  32      cmd_len of the completed command
// - err_overrun    out  1       sticky: more bytes counted than cmd_len; cleared only by reset
// - busy           out  1       high in any state except IDLE
// BEHAVIOUR
// - Reset: state IDLE, cmd_ready=1; dsc_byp_addr=0, dsc_byp_len=0, dsc_byp_load=0;
//   done_valid=0, done_tag=0, done_len=0, err_overrun=0, busy=0; all counters 0.
//   Reset mid-operation discards the command and any partial count.
// - FSM: IDLE -> ISSUE -> WAIT_DATA -> DONE -> IDLE.
// - IDLE: cmd_ready=1.
//   On accept: latch addr/len/tag; clear byte count; go to ISSUE (len>0) or DONE (len==0, no descriptor issued).
// - ISSUE: dsc_byp_addr/len are registered and stable until accepted.
//   seg = min(remaining, MAX_DSC_BYTES - (cur_addr & (MAX_DSC_BYTES-1))).
//   dsc_byp_load = (state==ISSUE) & dsc_byp_ready, combinational, so load is never high while ready is low.
//   Descriptor is accepted on the load cycle: cur_addr += seg, remaining -= seg, next addr/len registered for the following cycle.
//   Back-to-back loads are allowed, one per cycle.
//   remaining reaches 0 -> WAIT_DATA.
// - Monitor: while busy, every cycle with mon_valid & mon_ready adds popcount(mon_keep) to a 32-bit byte count.
//   This includes beats that arrive during ISSUE. Beats seen in IDLE or DONE are ignored.
// - WAIT_DATA: count >= cmd_len -> DONE. Count > cmd_len -> set err_overrun.
// - DONE: done_valid=1 for exactly one cycle with done_tag and done_len; next state IDLE.
//   cmd_ready is 0 in DONE, so at most one command is in flight.
// - Latency:
//   - accept -> first load possible the next cycle.
//   - final counted beat -> done_valid 1 cycle later.
//   - len==0 accept -> done_valid 1 cycle later.
// - Arithmetic: address wraps modulo 2^64. A seg of 0 is never issued.
// STRUCTURE
// - dma_dsc_pkg holds: state enum (IDLE, ISSUE, WAIT_DATA, DONE), the dsc_cmd_t struct {addr, len, tag}, and the popcount function width constants.
// - Sub-module keep_popcount: KEEP_W -> $clog2(KEEP_W)+1 bits, combinational.
// - One dma_dsc_issuer instance per channel and direction beside the DMA wrapper (4 c2h + 4 h2c).
// TESTING
// 1. Single descriptor.
//    Stimulus: addr=0x1000, len=256, ready=1; then 4 beats with keep all-ones.
//    Required: one load with (0x1000, 256); done_tag echoes the command; done_len=256; err_overrun=0.
// 2. Boundary split.
//    Stimulus: addr=0x7F00, len=0x300.
//    Required: loads (0x7F00, 0x100) then (0x8000, 0x200) on consecutive cycles.
// 3. Long transfer.
//    Stimulus: addr=0, len=0x18000.
//    Required: three loads of 0x8000 at 0, 0x8000, 0x10000; done only after 1536 full beats.
// 4. Ready low.
//    Stimulus: hold dsc_byp_ready=0 for 10 cycles while in ISSUE.
//    Required: load stays 0 and addr/len stay stable; the load fires in the cycle ready rises.
// 5. Zero-length and partial keep.
//    - Stimulus: len=0. Required: no load; done_valid 1 cycle after accept.
//    - Stimulus: len=100, beats with keep=all-ones then keep=0xF_FFFF_FFFF. Required: done, err_overrun=0.
// 6. Overrun and reset.
//    - Stimulus: len=64, two full beats. Required: err_overrun=1 and done fires.
//    - Stimulus: pcie_rst asserted mid-ISSUE. Required: all outputs return to reset values and cmd_ready=1.

Source files
------------

// File: rtl/dma_dsc_pkg.sv
// Shared types for the XDMA descriptor-bypass issuer.
// States, command bundle and popcount width helper.
package dma_dsc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } dsc_state_e;

  localparam int DSC_TAG_W = 8;

  typedef struct packed {
    logic [63:0]          addr;
    logic [31:0]          len;
    logic [DSC_TAG_W-1:0] tag;
  } dsc_cmd_t;

  function automatic int pop_w(input int keep_w);
    return $clog2(keep_w) + 1;
  endfunction

endpackage

// File: rtl/dma_dsc_issuer_keep_popcount.sv
// Counts set byte-enables of one stream beat.
// Purely combinational.
module keep_popcount
  import dma_dsc_pkg::*;
#(
  parameter  int KEEP_W = 64,
  localparam int CNT_W  = pop_w(KEEP_W)
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [CNT_W-1:0]  cnt
);

  // sum of enabled bytes
  always_comb begin
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/dma_dsc_issuer.sv
// Splits a host transfer command into bypass descriptors
// and reports completion once the paired stream moved cmd_len bytes.
module dma_dsc_issuer
  import dma_dsc_pkg::*;
#(
  parameter int MAX_DSC_BYTES = 32768,
  parameter int TAG_W         = DSC_TAG_W,
  parameter int KEEP_W        = 64
) (
  input  logic              pcie_clk,
  input  logic              pcie_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_addr,
  input  logic [31:0]       cmd_len,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              dsc_byp_ready,
  output logic [63:0]       dsc_byp_addr,
  output logic [31:0]       dsc_byp_len,
  output logic              dsc_byp_load,
  input  logic              mon_valid,
  input  logic              mon_ready,
  input  logic [KEEP_W-1:0] mon_keep,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic [31:0]       done_len,
  output logic              err_overrun,
  output logic              busy
);

  localparam int CNT_W = pop_w(KEEP_W);

  dsc_state_e        state_q, state_d;
  dsc_cmd_t          cmd_q, cmd_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       dsc_len_q, dsc_len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [63:0]       nxt_addr;
  logic [31:0]       nxt_rem;
  logic [CNT_W-1:0]  beat_bytes;

  // bytes up to the next aligned boundary, capped by what remains
  function automatic logic [31:0] seg_of(
    input logic [63:0] a,
    input logic [31:0] r
  );
    logic [31:0] room;
    room = 32'(MAX_DSC_BYTES) -
           32'(a & 64'(MAX_DSC_BYTES - 1));
    return (r < room) ? r : room;
  endfunction

  keep_popcount #(
    .KEEP_W (KEEP_W)
  ) u_pop (
    .keep (mon_keep),
    .cnt  (beat_bytes)
  );

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dsc_byp_addr = cmd_q.addr;
  assign dsc_byp_len  = dsc_len_q;
  assign dsc_byp_load = (state_q == ISSUE) & dsc_byp_ready;
  assign done_valid   = (state_q == DONE);
  assign done_tag     = TAG_W'(cmd_q.tag);
  assign done_len     = cmd_q.len;
  assign err_overrun  = err_q;

  // next-state, descriptor walk and byte monitor
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rem_d     = rem_q;
    dsc_len_d = dsc_len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    nxt_addr  = cmd_q.addr + 64'(dsc_len_q);
    nxt_rem   = rem_q - dsc_len_q;

    if (mon_valid && mon_ready &&
        (state_q == ISSUE || state_q == WAIT_DATA)) begin
      cnt_d = cnt_q + 32'(beat_bytes);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.addr = cmd_addr;
          cmd_d.len  = cmd_len;
          cmd_d.tag  = DSC_TAG_W'(cmd_tag);
          rem_d      = cmd_len;
          dsc_len_d  = seg_of(cmd_addr, cmd_len);
          cnt_d      = '0;
          state_d    = (cmd_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (dsc_byp_ready) begin
          cmd_d.addr = nxt_addr;
          rem_d      = nxt_rem;
          dsc_len_d  = seg_of(nxt_addr, nxt_rem);
          if (nxt_rem == '0) begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (cnt_d > cmd_q.len) begin
          err_d = 1'b1;
        end
        if (cnt_d >= cmd_q.len) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rem_q     <= '0;
      dsc_len_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      dsc_len_q <= dsc_len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule
